// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write bypass and a busy
// scoreboard that decode uses to stall on RAW hazards.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rready,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_err,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  we0;
  logic [DEPTH-1:0]  we1;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  al_hit;
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              err_d;
  logic              alloc_zero;

  // Per-register decode; the zero register never sees writes or allocs.
  always_comb begin
    we0    = '0;
    we1    = '0;
    al_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we0[i]    = wen0 && (waddr0 == ADDR_W'(i));
      we1[i]    = wen1 && (waddr1 == ADDR_W'(i));
      al_hit[i] = alloc_en && (alloc_addr == ADDR_W'(i));
    end
    if (ZR) begin
      we0[0]    = 1'b0;
      we1[0]    = 1'b0;
      al_hit[0] = 1'b0;
    end
  end

  assign wr_hit     = we0 | we1;
  assign alloc_zero = ZR && (alloc_addr == '0);

  // A new producer outranks a retiring one on the same register.
  assign busy_d = (busy_q & ~wr_hit) | al_hit;

  assign err_d = alloc_en
               & busy_q[alloc_addr]
               & ~wr_hit[alloc_addr]
               & ~alloc_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we1[i]) begin
          regs[i] <= wdata1;
        end else if (we0[i]) begin
          regs[i] <= wdata0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      alloc_err <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      alloc_err <= err_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              r;

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs[ra];
      r = !busy_q[ra];
      if (BP) begin
        if (wen1 && (waddr1 == ra)) begin
          d = wdata1;
          r = 1'b1;
        end else if (wen0 && (waddr0 == ra)) begin
          d = wdata0;
          r = 1'b1;
        end
      end
      if (ZR && (ra == '0)) begin
        d = '0;
        r = 1'b1;
      end
    end

    assign rdata[p*DATA_W +: DATA_W] = d;
    assign rready[p]                 = r;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the CPU datapath: DEPTH x DATA_W storage, NUM_RD combinational read ports and two write ports.
- Optional hardwired zero register and optional write-to-read bypass.
- Per-register busy scoreboard, set at issue and cleared at writeback, so decode can stall on RAW hazards.
- Sits between decode (read and allocate) and writeback (write).

Parameters:
DATA_W, 16, data width in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0, is never written and is never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
wen0  in  1  write port 0 enable
waddr0  in  ADDR_W  write port 0 address
wdata0  in  DATA_W  write port 0 data
wen1  in  1  write port 1 enable (higher priority than port 0)
waddr1  in  ADDR_W  write port 1 address
wdata1  in  DATA_W  write port 1 data
raddr  in  NUM_RD*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port p uses slice [p*DATA_W +: DATA_W]
rready  out  NUM_RD  1 = rdata[p] is architecturally valid (not awaiting writeback)
alloc_en  in  1  mark register alloc_addr busy (instruction issued with this destination)
alloc_addr  in  ADDR_W  register to allocate
alloc_err  out  1  registered 1-cycle pulse: allocation to an already-busy register
busy_vec  out  DEPTH  current scoreboard state

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0; busy_vec=0; alloc_err=0.
  - While rst=0 and no bypass is active: rdata=0 and rready=all ones.
  - Deassertion takes effect at the first clk edge after rst=1.
- Writes:
  - At the rising edge, reg[waddrN] <= wdataN when wenN=1.
  - If both ports write the same address, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Reads (combinational, zero latency):
  - rdata[p] = reg[raddr[p]].
  - With BYPASS=1: if wen1 and waddr1==raddr[p], rdata[p]=wdata1; else if wen0 and waddr0==raddr[p], rdata[p]=wdata0.
  - With BYPASS=0, new data is visible the cycle after the write edge.
  - With ZERO_REG=1, a read of address 0 returns 0 regardless of any bypass.
- Scoreboard, per register i, at each rising edge:
  - set when alloc_en and alloc_addr==i;
  - else cleared when any write port writes i;
  - else held.
  - Alloc and write to the same register in the same cycle: busy ends at 1 (the new producer wins). The write data is still stored.
  - With ZERO_REG=1, alloc to register 0 is ignored and busy_vec[0] is constant 0.
- rready[p]:
  - = !busy_vec[raddr[p]] when BYPASS=0.
  - When BYPASS=1, rready[p] is additionally 1 if a write to raddr[p] occurs this cycle.
  - ZERO_REG address 0 is always ready.
- alloc_err:
  - Registered; alloc_err <= alloc_en & busy_vec[alloc_addr] & !(a write to alloc_addr this cycle) & !(ZERO_REG and alloc_addr==0).
  - Informational only: the allocation is still performed.
- No X propagation: unused address bits and out-of-range NUM_RD slices are not permitted; all DEPTH registers exist.
- Reset mid-operation: state clears immediately and pending allocs and writes in that cycle are lost.

Test Plan:
1. Reset then read all 16 addresses on both ports -> rdata=0x0000, rready=2'b11, busy_vec=0, alloc_err=0.
2. wen0 (r5, 0x1234), next cycle read r5 on port 0 -> rdata0=0x1234. Same-cycle read with BYPASS=1 -> 0x1234; with BYPASS=0 -> the old value 0x0000.
3. wen0 (r3, 0xAAAA) and wen1 (r3, 0x5555) in one cycle -> r3=0x5555, and bypassed read in that cycle also 0x5555. wen1 to r0, 0xFFFF -> r0 reads 0x0000.
4. alloc r7; next cycle read r7 -> rready0=0 and busy_vec[7]=1. Writeback r7=0xBEEF -> same cycle rready0=1 with rdata0=0xBEEF (BYPASS=1); next cycle busy_vec[7]=0.
5. alloc r9 twice in consecutive cycles -> alloc_err=1 for exactly one cycle after the second alloc. alloc r9 together with a write to r9 while busy -> busy stays 1, alloc_err=0.
6. Write r2=0x00FF and alloc r4, then pull rst low mid-cycle -> immediately r2=0, busy_vec=0 and alloc_err=0, without waiting for a clk edge.
